// File: rtl/blf_gen.sv
// blf_gen: fractional-N divider for the DOUB_BLF clock.
// Shadowed config, boundary-aligned updates, drain-to-boundary stop.
module blf_gen #(
    parameter int INT_W  = 6,
    parameter int FRAC_W = 2
) (
    input  logic              clk_1_92m,
    input  logic              rst_n,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_load,
    input  logic              start,
    input  logic              stop,
    output logic              blf_clk,
    output logic              blf_tick,
    output logic              busy,
    output logic              cfg_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [INT_W:0]   CNT_ONE = (INT_W+1)'(1);
    localparam logic [INT_W-1:0] INT_MIN = INT_W'(2);

    state_t            state_q, state_d;
    logic [INT_W-1:0]  sh_int, act_int, nxt_int;
    logic [FRAC_W-1:0] sh_frac, act_frac, nxt_frac, acc;
    logic              sh_valid, err_q;
    logic [INT_W:0]    cnt, per, half;
    logic [FRAC_W:0]   sum;
    logic              load_ok, active, last, go, new_period;

    assign load_ok    = cfg_load && (cfg_int >= INT_MIN);
    assign active     = (state_q != IDLE);
    assign go         = (state_q == IDLE) && start && !stop && sh_valid;

    // acc holds the phase at the start of the current period
    assign sum        = {1'b0, acc} + {1'b0, act_frac};
    assign per        = {1'b0, act_int} + {{INT_W{1'b0}}, sum[FRAC_W]};
    assign half       = (per + CNT_ONE) >> 1;
    assign last       = active && (cnt == per - CNT_ONE);
    assign new_period = go || last;

    // a valid load on the boundary cycle feeds the next period directly
    always_comb begin
        nxt_int  = sh_int;
        nxt_frac = sh_frac;
        if (last && load_ok) begin
            nxt_int  = cfg_int;
            nxt_frac = cfg_frac;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN:     if (stop) state_d = last ? IDLE : DRAIN;
            DRAIN: begin
                if (start)     state_d = RUN;
                else if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            sh_int   <= '0;
            sh_frac  <= '0;
            sh_valid <= 1'b0;
            err_q    <= 1'b0;
        end else if (load_ok) begin
            sh_int   <= cfg_int;
            sh_frac  <= cfg_frac;
            sh_valid <= 1'b1;
            err_q    <= 1'b0;
        end else if (cfg_load) begin
            err_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk_1_92m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            act_int  <= '0;
            act_frac <= '0;
        end else begin
            state_q <= state_d;
            if (new_period) begin
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
                acc      <= go ? '0 : sum[FRAC_W-1:0];
            end
            if (state_d == IDLE || new_period) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign busy     = active;
    assign blf_tick = active && (cnt == '0);
    assign blf_clk  = active && (cnt < half);
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_blf_gen.sv
// tb_blf_gen: scenario tasks for blf_gen checked against a
// period-level behavioural model of the divider.
module tb_blf_gen;
    logic       clk_1_92m = 1'b0;
    logic       rst_n;
    logic [5:0] cfg_int;
    logic [1:0] cfg_frac;
    logic       cfg_load, start, stop;
    logic       blf_clk, blf_tick, busy, cfg_err;

    int total = 0;
    int bad   = 0;

    // model: running flag, position in period, period length, phase
    bit m_run, m_drain, m_sv, m_err;
    int m_pos, m_len, m_acc, m_si, m_sf;

    blf_gen #(.INT_W(6), .FRAC_W(2)) dut (
        .clk_1_92m(clk_1_92m),
        .rst_n    (rst_n),
        .cfg_int  (cfg_int),
        .cfg_frac (cfg_frac),
        .cfg_load (cfg_load),
        .start    (start),
        .stop     (stop),
        .blf_clk  (blf_clk),
        .blf_tick (blf_tick),
        .busy     (busy),
        .cfg_err  (cfg_err)
    );

    always #5 clk_1_92m = ~clk_1_92m;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_run = 0; m_drain = 0; m_sv = 0; m_err = 0;
        m_pos = 0; m_len = 0; m_acc = 0; m_si = 0; m_sf = 0;
    endfunction

    function automatic void model_period(input int i, input int f);
        int s;
        s     = m_acc + f;
        m_len = i + s / 4;
        m_acc = s % 4;
    endfunction

    function automatic void model_step(input bit ld, input int ci,
                                       input int cf, input bit st,
                                       input bit sp);
        int osi, osf;
        bit osv, bnd, keep;
        osi = m_si; osf = m_sf; osv = m_sv;
        if (ld && ci >= 2) begin
            m_si = ci; m_sf = cf; m_sv = 1; m_err = 0;
        end else if (ld) begin
            m_err = 1;
        end
        if (!m_run) begin
            if (st && !sp && osv) begin
                m_run = 1; m_drain = 0; m_acc = 0; m_pos = 0;
                model_period(osi, osf);
            end
        end else begin
            bnd  = (m_pos == m_len - 1);
            keep = 1;
            if (m_drain) begin
                if (st) m_drain = 0;
                else if (bnd) keep = 0;
            end else if (sp) begin
                if (bnd) keep = 0;
                else m_drain = 1;
            end
            if (!keep) begin
                m_run = 0; m_drain = 0; m_pos = 0;
            end else if (bnd) begin
                m_pos = 0;
                model_period(m_si, m_sf);
            end else begin
                m_pos++;
            end
        end
    endfunction

    function automatic logic [3:0] exp_outs();
        bit t, c;
        t = m_run && (m_pos == 0);
        c = m_run && (m_pos < (m_len + 1) / 2);
        return {t, c, m_run, m_err};
    endfunction

    task automatic drive(input bit ld, input int ci, input int cf,
                         input bit st, input bit sp);
        cfg_load = ld;
        cfg_int  = 6'(ci);
        cfg_frac = 2'(cf);
        start    = st;
        stop     = sp;
        @(posedge clk_1_92m);
        model_step(ld, ci, cf, st, sp);
        @(negedge clk_1_92m);
        cfg_load = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0; cfg_load = 0; start = 0; stop = 0;
        cfg_int = '0; cfg_frac = '0;
        model_reset();
        #12;
        got = {blf_tick, blf_clk, busy, cfg_err};
        total++;
        if (got !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold got=%b want=0000", got);
        end
        @(negedge clk_1_92m);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0);
        got = {blf_tick, blf_clk, busy, cfg_err};
        total++;
        if (got !== 4'b0000) begin
            bad++;
            $display("FAIL reset_start_noload got=%b want=0000", got);
        end
    endtask

    task automatic test_div4();
        logic [3:0] got, want;
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            got  = {blf_tick, blf_clk, busy, cfg_err};
            want = {i % 4 == 0, i % 4 < 2, 1'b1, 1'b0};
            total++;
            if (got !== want || want !== exp_outs()) begin
                bad++;
                $display("FAIL div4 i=%0d got=%b want=%b", i, got, want);
            end
            drive(0, 0, 0, 0, i == 11);
        end
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL div4_drain k=%0d got=%b want=%b",
                         k, got, want);
            end
            drive(0, 0, 0, 0, 0);
        end
        total++;
        if (busy !== 1'b0 || blf_clk !== 1'b0) begin
            bad++;
            $display("FAIL div4_idle busy=%b clk=%b want=0", busy, blf_clk);
        end
    endtask

    task automatic test_frac();
        logic [3:0] got, want;
        int lens[4];
        int t;
        lens = '{3, 4, 3, 4};
        t = 0;
        drive(1, 3, 2, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < lens[p]; j++) begin
                got  = {blf_tick, blf_clk, busy, cfg_err};
                want = {j == 0, j < 2, 1'b1, 1'b0};
                total++;
                if (got !== want || want !== exp_outs()) begin
                    bad++;
                    $display("FAIL frac t=%0d got=%b want=%b", t, got, want);
                end
                t++;
                drive(0, 0, 0, 0, t == 14);
            end
        end
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL frac_drain k=%0d got=%b want=%b",
                         k, got, want);
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_cfg_err();
        logic [3:0] got, want;
        int ticks[$];
        int gaps[4];
        gaps = '{4, 4, 5, 5};
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int t = 0; t < 20; t++) begin
            got  = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want || (t >= 3 && t <= 6 && cfg_err !== 1'b1)) begin
                bad++;
                $display("FAIL cfg_err t=%0d got=%b want=%b", t, got, want);
            end
            if (blf_tick) ticks.push_back(t);
            if (t == 2)      drive(1, 1, 0, 0, 0);
            else if (t == 6) drive(1, 5, 0, 0, 0);
            else             drive(0, 0, 0, 0, 0);
        end
        total++;
        if (ticks.size() != 5) begin
            bad++;
            $display("FAIL cfg_err_ticks got=%0d want=5", ticks.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                total++;
                if (ticks[g+1] - ticks[g] != gaps[g]) begin
                    bad++;
                    $display("FAIL cfg_err_gap g=%0d got=%0d want=%0d",
                             g, ticks[g+1] - ticks[g], gaps[g]);
                end
            end
        end
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cfg_err_drain k=%0d got=%b want=%b",
                         k, got, want);
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_stop_drain();
        logic [3:0] got;
        logic [3:0] seq_a[8];
        logic [3:0] seq_b[6];
        seq_a = '{4'b1110, 4'b0110, 4'b0010, 4'b0010,
                  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        seq_b = '{4'b1110, 4'b0110, 4'b0010, 4'b0010,
                  4'b1110, 4'b0110};
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            total++;
            if (got !== seq_a[i]) begin
                bad++;
                $display("FAIL stop_drain i=%0d got=%b want=%b",
                         i, got, seq_a[i]);
            end
            drive(0, 0, 0, 0, i == 1);
        end
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            total++;
            if (got !== seq_b[i]) begin
                bad++;
                $display("FAIL drain_restart i=%0d got=%b want=%b",
                         i, got, seq_b[i]);
            end
            drive(0, 0, 0, i == 2, i == 1 || i == 5);
        end
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            total++;
            if (got !== exp_outs()) begin
                bad++;
                $display("FAIL restart_drain k=%0d got=%b want=%b",
                         k, got, exp_outs());
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_load_boundary();
        logic [3:0] got, want;
        int ticks[$];
        int gaps[4];
        gaps = '{4, 6, 4, 6};
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int t = 0; t <= 20; t++) begin
            got  = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_bnd t=%0d got=%b want=%b", t, got, want);
            end
            if (blf_tick) ticks.push_back(t);
            if (t == 1 || t == 13) drive(1, 6, 0, 0, 0);
            else if (t == 6)       drive(1, 4, 0, 0, 0);
            else                   drive(0, 0, 0, 0, 0);
        end
        total++;
        if (ticks.size() != 5) begin
            bad++;
            $display("FAIL load_bnd_ticks got=%0d want=5", ticks.size());
        end else begin
            for (int g = 0; g < 4; g++) begin
                total++;
                if (ticks[g+1] - ticks[g] != gaps[g]) begin
                    bad++;
                    $display("FAIL load_bnd_gap g=%0d got=%0d want=%0d",
                             g, ticks[g+1] - ticks[g], gaps[g]);
                end
            end
        end
        drive(0, 0, 0, 0, 1);
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_bnd_drain k=%0d got=%b want=%b",
                         k, got, want);
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_max_period();
        logic [3:0] got, want;
        int ticks[$];
        drive(1, 63, 3, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int t = 0; t <= 127; t++) begin
            got  = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL max_per t=%0d got=%b want=%b", t, got, want);
            end
            if (blf_tick) ticks.push_back(t);
            drive(0, 0, 0, 0, t == 127);
        end
        total++;
        if (ticks.size() != 3 || ticks[1] != 63 || ticks[2] != 127) begin
            bad++;
            $display("FAIL max_per_ticks got=%p want=0,63,127", ticks);
        end
        for (int k = 0; k < 80 && m_run; k++) begin
            got = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL max_per_drain k=%0d got=%b want=%b",
                         k, got, want);
            end
            drive(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] got;
        drive(1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        repeat (5) drive(0, 0, 0, 0, 0);
        @(posedge clk_1_92m);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        got = {blf_tick, blf_clk, busy, cfg_err};
        total++;
        if (got !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset got=%b want=0000", got);
        end
        @(negedge clk_1_92m);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        got = {blf_tick, blf_clk, busy, cfg_err};
        total++;
        if (got !== 4'b0000 || got !== exp_outs()) begin
            bad++;
            $display("FAIL post_reset_start got=%b want=0000", got);
        end
    endtask

    task automatic test_random();
        logic [3:0] got, want;
        bit ld, st, sp;
        int ci, cf;
        for (int t = 0; t < 600; t++) begin
            got  = {blf_tick, blf_clk, busy, cfg_err};
            want = exp_outs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random t=%0d got=%b want=%b", t, got, want);
            end
            ld = ($urandom % 8) == 0;
            ci = int'($urandom % 10);
            cf = int'($urandom % 4);
            st = ($urandom % 6) == 0;
            sp = ($urandom % 10) == 0;
            drive(ld, ci, cf, st, sp);
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_frac();
        test_cfg_err();
        test_stop_drain();
        test_load_boundary();
        test_max_period();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blf_gen.md
BLF_GEN -- requirements
Module: blf_gen

Interface
REQ-001 The block SHALL have parameter INT_W, default 6, meaning the width of the integer divisor.
REQ-002 The block SHALL have parameter FRAC_W, default 2, meaning the width of the fractional divisor (LSB = 1/2^FRAC_W clock).
REQ-003 Port clk_1_92m  input  1  is the single main clock; all flops are clocked on its rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port cfg_int  input  INT_W  is the integer part of the period, in clk_1_92m cycles.
REQ-006 Port cfg_frac  input  FRAC_W  is the fractional part of the period.
REQ-007 Port cfg_load  input  1  is a one-cycle strobe that samples cfg_int and cfg_frac.
REQ-008 Port start  input  1  is a one-cycle request to begin generation.
REQ-009 Port stop  input  1  is a one-cycle request to end generation at a period boundary.
REQ-010 Port blf_clk  output  1  is the divided (DOUB_BLF) clock level.
REQ-011 Port blf_tick  output  1  is a one-cycle pulse marking the first cycle of each period.
REQ-012 Port busy  output  1  is high whenever the state is not IDLE.
REQ-013 Port cfg_err  output  1  is a sticky flag indicating that the last load was invalid.

Function
REQ-014 The block SHALL hold shadow config (sh_int, sh_frac, sh_valid) and active config (act_int, act_frac); cfg_load with cfg_int>=2 SHALL write the shadow, set sh_valid and clear cfg_err.
REQ-015 cfg_load with cfg_int<2 SHALL set cfg_err and leave the shadow and the active config unchanged.
REQ-016 The block SHALL implement states IDLE, RUN and DRAIN, encoded in registers.
REQ-017 In IDLE, start with sh_valid=1 and no stop SHALL copy shadow to active, clear acc and cnt, and enter RUN; start with sh_valid=0, or start together with stop, SHALL be ignored.
REQ-018 Period length P = act_int + carry, where carry=1 when acc+act_frac >= 2^FRAC_W; acc (FRAC_W bits) SHALL update to (acc+act_frac) mod 2^FRAC_W once per period, at the period's first cycle.
REQ-019 cnt (INT_W+1 bits) SHALL count 0..P-1 in RUN/DRAIN and wrap to 0; P reaches a maximum of 2^INT_W without overflow.
REQ-020 blf_tick SHALL be 1 when state is RUN or DRAIN and cnt==0.
REQ-021 blf_clk SHALL be 1 when state is RUN or DRAIN and cnt < ceil(P/2), and 0 otherwise.
REQ-022 Outputs SHALL be decoded from registers only, with no combinational path from inputs to outputs.
REQ-023 At each boundary (cnt==P-1), the block SHALL copy shadow to active; a valid cfg_load in that same cycle SHALL bypass and apply to the immediately following period.
REQ-024 A period in progress SHALL never change length because of a load.
REQ-025 stop in RUN with cnt!=P-1 SHALL move the block to DRAIN; stop in RUN with cnt==P-1 SHALL move it to IDLE after that cycle.
REQ-026 DRAIN SHALL finish the current period, then enter IDLE; blf_clk therefore ends low after a full period.
REQ-027 start in DRAIN SHALL return the block to RUN without a gap; start in RUN SHALL be ignored; stop in IDLE or DRAIN SHALL be ignored.
REQ-028 First blf_tick SHALL appear in the cycle after start is sampled.

Reset
REQ-029 When rst_n is low, the block SHALL asynchronously force state=IDLE, cnt=0, acc=0, all config registers=0, sh_valid=0, cfg_err=0, blf_clk=0, blf_tick=0 and busy=0.
REQ-030 After reset is released, a fresh valid cfg_load SHALL be required before start is accepted.

Verification
REQ-031 The bench SHALL cover: load int=4 frac=0, then start -> blf_tick every 4 cycles, blf_clk 1,1,0,0 repeating, busy=1.
REQ-032 The bench SHALL cover: FRAC_W=2, load int=3 frac=2, then start -> periods 3,4,3,4..., blf_clk high 2 cycles per period, average period 3.5.
REQ-033 The bench SHALL cover: load int=1 while running int=4 -> cfg_err=1 and the period stays 4; then a valid load int=5 -> cfg_err=0 and the period becomes 5 from the next boundary.
REQ-034 The bench SHALL cover: stop at cnt=1 of a 4-cycle period -> DRAIN, busy falls after cnt=3, and no further tick; repeating this with start at cnt=2 -> RUN continues and a tick follows cnt=3 directly.
REQ-035 The bench SHALL cover: load int=6 at cnt=1 of a 4-cycle period -> current period 4, next period 6; load at cnt=3 (boundary) -> the next period is 6.
REQ-036 The bench SHALL cover: rst_n low mid-RUN -> all outputs 0 immediately; after release, start without a load -> ignored, busy=0.
